fifo_rd_stream_adapter: RTL
===========================

// Module: fifo_rd_stream_adapter
// PURPOSE
//  Read-side drain engine for the team's FIFO IP: drives rd_en against rd_empty, absorbs the 1-cycle RAM
//  read latency and presents a valid/ready stream with zero bubbles at full throughput. It sits between the
//  FIFO read port (c_OUTPUT_REG=0, rd_oce tied 1) and any downstream consumer that may stall.
// PARAMETERS
//  DATA_WIDTH  32  width of fifo_rd_data / m_data, 1..1152
//  BUF_DEPTH   2   prefetch skid-buffer entries, legal 2..4 (2 is the minimum for full throughput)
//  LVL_WIDTH   3   width of buf_level, must satisfy 2^LVL_WIDTH > BUF_DEPTH
// PORTS
//  rd_clk         in   1           single clock, the FIFO read clock
//  rd_rst         in   1           synchronous, active-high reset
//  flush          in   1           synchronous clear of buffer and in-flight read (data dropped)
//  fifo_rd_en     out  1           to FIFO rd_en; also used as the RAM read clock enable
//  fifo_rd_data   in   DATA_WIDTH  from FIFO rd_data; valid exactly 1 cycle after fifo_rd_en
//  fifo_rd_empty  in   1           from FIFO rd_empty
//  m_data         out  DATA_WIDTH  stream data = head of buffer
//  m_valid        out  1           stream valid
//  m_ready        in   1           stream ready; transfer when m_valid && m_ready
//  buf_level      out  LVL_WIDTH   words held in buffer, excluding in-flight
// BEHAVIOUR
//  - Reset (rd_rst=1 at posedge): fifo_rd_en=0, m_valid=0, m_data=0, buf_level=0, pend=0, pointers=0.
//  - pend: 1-bit register = fifo_rd_en of previous cycle (a word arrives this cycle).
//  - pop = m_valid & m_ready. issue = !fifo_rd_empty & !flush & (buf_level + pend - pop < BUF_DEPTH).
//    fifo_rd_en = issue, combinational from registered state, fifo_rd_empty and m_ready. Never asserted
//    when fifo_rd_empty=1, so the FIFO is never underflowed.
//  - Arrival: when pend=1, fifo_rd_data is written at wr_ptr. Circular buffer, wr_ptr/rd_ptr wrap
//    BUF_DEPTH-1 -> 0.
//  - Push and pop in the same cycle: level unchanged and both pointers advance. A word arriving into an
//    empty buffer is visible on m_data/m_valid the following cycle (rd_en -> m_valid latency = 2 cycles).
//  - m_data and m_valid are held stable while m_valid=1 and m_ready=0 (AXI-style; no retraction).
//  - Throughput: with m_ready=1 and a non-empty FIFO, one word per cycle sustained.
//  - Full buffer with m_ready=0: fifo_rd_en=0. Accounting for pend guarantees no overflow.
//  - flush=1: next cycle buf_level=0, m_valid=0, pend=0. A word in flight during the flush cycle is
//    discarded. fifo_rd_en=0 during flush. rd_rst dominates flush.
//  - Reset mid-stream: the buffered words are lost. The FIFO read pointer is not rewound, so the caller
//    must reset the FIFO together with this block.
//  - Order is strictly preserved; there are no data-dependent paths.
// CONFIGURATION
//  FIFO_RD_WORD_CNT_EN defined: adds output word_cnt [31:0]. It increments on every pop, wraps
//    0xFFFFFFFF -> 0, and is cleared by rd_rst and by flush.
//  Undefined: no word_cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//  Shared package fifo_rd_pkg: DATA_WIDTH_MAX=1152, BUF_DEPTH_MIN=2, BUF_DEPTH_MAX=4,
//    typedef lvl_t (LVL_WIDTH-bit level), typedef ptr_t (2-bit pointer).
//  One sub-module, fifo_rd_skid_buf: the circular buffer plus level/pointer logic
//    (push, pop, clr -> data, valid, level).
//  The top level holds the issue/pend logic and the optional counter.
// TESTING (bench models the FIFO read port with 1-cycle latency, DATA_WIDTH=32, BUF_DEPTH=2)
//  1. Preload 8 words 0x10..0x17, m_ready=1 -> m_valid rises 2 cycles after the first rd_en; 8 words
//     on 8 consecutive cycles, in order; fifo_rd_en drops when rd_empty=1.
//  2. Preload 8 words, hold m_ready=0 -> exactly 2 rd_en pulses, buf_level=2, m_data=0x10 stable;
//     releasing m_ready streams the rest with no gap.
//  3. Random m_ready (50%) with random FIFO fills, 10k words -> scoreboard matches exactly,
//     no rd_en while empty, buf_level <= 2 at all times.
//  4. buf_level=1 with a word in flight, assert flush -> next cycle m_valid=0, buf_level=0, and the
//     in-flight word is never emitted.
//  5. rd_rst during streaming (with the FIFO model reset) -> all outputs are 0 the next cycle; the
//     stream resumes correctly after refill.
//  6. With FIFO_RD_WORD_CNT_EN: pop 5 words -> word_cnt=5; flush -> 0. Force 0xFFFFFFFF and pop ->
//     word_cnt=0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and limits for the FIFO read-side stream adapter.
package fifo_rd_pkg;

    localparam int DATA_WIDTH_MAX = 1152;
    localparam int BUF_DEPTH_MIN  = 2;
    localparam int BUF_DEPTH_MAX  = 4;
    localparam int LVL_WIDTH_DEF  = 3;

    typedef logic [LVL_WIDTH_DEF-1:0] lvl_t;
    typedef logic [1:0]               ptr_t;

    // Advance a circular-buffer pointer, wrapping depth-1 -> 0.
    function automatic ptr_t ptr_inc(input ptr_t p, input int depth);
        return (int'(p) == depth - 1) ? ptr_t'(0) : ptr_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus valid/ready stream for fifo_rd_stream_adapter.
// Optional FIFO_RD_WORD_CNT_EN adds the word_cnt signal.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LVL_WIDTH  = 3
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [LVL_WIDTH-1:0]  buf_level;
`ifdef FIFO_RD_WORD_CNT_EN
    logic [31:0]           word_cnt;

    modport master (
        output fifo_rd_en, input fifo_rd_data, input fifo_rd_empty,
        output m_data, output m_valid, input m_ready,
        output buf_level, output word_cnt
    );
    modport slave (
        input fifo_rd_en, output fifo_rd_data, output fifo_rd_empty,
        input m_data, input m_valid, output m_ready,
        input buf_level, input word_cnt
    );
`else
    modport master (
        output fifo_rd_en, input fifo_rd_data, input fifo_rd_empty,
        output m_data, output m_valid, input m_ready,
        output buf_level
    );
    modport slave (
        input fifo_rd_en, output fifo_rd_data, output fifo_rd_empty,
        input m_data, input m_valid, output m_ready,
        input buf_level
    );
`endif
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular prefetch buffer: push at wr_ptr, pop at rd_ptr, level tracking, clr empties it.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int LVL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [LVL_WIDTH-1:0]  level
);

    // Sized to the largest legal depth so a 2-bit pointer indexes it exactly.
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH_MAX];
    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    logic [LVL_WIDTH-1:0]  level_q, level_d;

    // Next-state for pointers and level; clr wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q, BUF_DEPTH);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q, BUF_DEPTH);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_WIDTH'(1);
                2'b01:   level_d = level_q - LVL_WIDTH'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Data storage; a word arriving during a clear is dropped.
    always_ff @(posedge clk) begin
        if (push && !clr && !srst) mem_q[wr_ptr_q] <= push_data;
    end

    // Head of buffer, forced to zero while empty so reset/flush show m_data=0.
    always_comb begin
        head_data = '0;
        if (level_q != '0) head_data = mem_q[rd_ptr_q];
    end

    assign head_valid = (level_q != '0);
    assign level      = level_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain engine: issues FIFO reads against rd_empty, absorbs the 1-cycle RAM
// latency and presents a bubble-free valid/ready stream.
// Optional FIFO_RD_WORD_CNT_EN adds a 32-bit popped-word counter on bus.word_cnt.
module fifo_rd_stream_adapter
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int LVL_WIDTH  = 3
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic                     flush,
    fifo_rd_stream_adapter_if.master bus
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
        $error("DATA_WIDTH out of range");
    end
    if (BUF_DEPTH < BUF_DEPTH_MIN || BUF_DEPTH > BUF_DEPTH_MAX) begin : g_bad_depth
        $error("BUF_DEPTH out of range");
    end
    if ((1 << LVL_WIDTH) <= BUF_DEPTH) begin : g_bad_lvl
        $error("LVL_WIDTH too narrow for BUF_DEPTH");
    end

    logic                  pend_q, pend_d;
    logic                  pop, issue, push;
    logic [LVL_WIDTH:0]    occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_valid;
    logic [LVL_WIDTH-1:0]  level;

    // Occupancy after this cycle counts the word in flight, so a new read never overflows.
    assign pop   = head_valid & bus.m_ready;
    assign occ   = {1'b0, level} + {{LVL_WIDTH{1'b0}}, pend_q} - {{LVL_WIDTH{1'b0}}, pop};
    assign issue = !bus.fifo_rd_empty && !flush && (occ < (LVL_WIDTH+1)'(BUF_DEPTH));
    assign push  = pend_q && !flush;

    // A read issued this cycle delivers its word next cycle.
    always_comb begin
        pend_d = issue;
    end

    // In-flight flag register.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) pend_q <= 1'b0;
        else        pend_q <= pend_d;
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .LVL_WIDTH  (LVL_WIDTH)
    ) u_skid (
        .clk        (rd_clk),
        .srst       (rd_rst),
        .push       (push),
        .push_data  (bus.fifo_rd_data),
        .pop        (pop),
        .clr        (flush),
        .head_data  (head_data),
        .head_valid (head_valid),
        .level      (level)
    );

    assign bus.fifo_rd_en = issue;
    assign bus.m_data     = head_data;
    assign bus.m_valid    = head_valid;
    assign bus.buf_level  = level;

`ifdef FIFO_RD_WORD_CNT_EN
    logic [31:0] word_cnt_q, word_cnt_d;

    // Count accepted words; wraps naturally, cleared by flush.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (flush)    word_cnt_d = '0;
        else if (pop) word_cnt_d = word_cnt_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) word_cnt_q <= '0;
        else        word_cnt_q <= word_cnt_d;
    end

    assign bus.word_cnt = word_cnt_q;
`endif

endmodule
